// File: rtl/ascon_arbiter_if.sv
// Requester and core-side stream bundle for the two-port Ascon arbiter.
// slave is the arbiter's view, master the surrounding system's view.
interface ascon_arbiter_if #(
    parameter int CCW = 32
);
    logic [1:0][3:0]       req_mode;
    logic [1:0]            req_start;
    logic [1:0]            req_grant;
    logic [1:0][CCW-1:0]   req_key;
    logic [1:0]            req_key_valid;
    logic [1:0]            req_key_ready;
    logic [1:0][CCW-1:0]   req_bdi;
    logic [1:0][CCW/8-1:0] req_bdi_valid;
    logic [1:0]            req_bdi_ready;
    logic [1:0][3:0]       req_bdi_type;
    logic [1:0]            req_bdi_eot;
    logic [1:0]            req_bdi_eoi;
    logic [1:0][CCW-1:0]   req_bdo;
    logic [1:0]            req_bdo_valid;
    logic [1:0]            req_bdo_ready;
    logic [1:0][3:0]       req_bdo_type;
    logic [1:0]            req_bdo_eot;
    logic [1:0]            req_bdo_eoo;
    logic [1:0]            req_done;
    logic [1:0]            req_auth;
    logic [1:0]            req_auth_valid;

    logic [3:0]            core_mode;
    logic [CCW-1:0]        core_key;
    logic                  core_key_valid;
    logic                  core_key_ready;
    logic [CCW-1:0]        core_bdi;
    logic [CCW/8-1:0]      core_bdi_valid;
    logic                  core_bdi_ready;
    logic [3:0]            core_bdi_type;
    logic                  core_bdi_eot;
    logic                  core_bdi_eoi;
    logic [CCW-1:0]        core_bdo;
    logic                  core_bdo_valid;
    logic                  core_bdo_ready;
    logic [3:0]            core_bdo_type;
    logic                  core_bdo_eot;
    logic                  core_bdo_eoo;
    logic                  core_auth;
    logic                  core_auth_valid;
    logic                  core_done;

    modport slave (
        input  req_mode,
        output req_start,
        output req_grant,
        input  req_key,
        input  req_key_valid,
        output req_key_ready,
        input  req_bdi,
        input  req_bdi_valid,
        output req_bdi_ready,
        input  req_bdi_type,
        input  req_bdi_eot,
        input  req_bdi_eoi,
        output req_bdo,
        output req_bdo_valid,
        input  req_bdo_ready,
        output req_bdo_type,
        output req_bdo_eot,
        input  req_bdo_eoo,
        output req_done,
        output req_auth,
        output req_auth_valid,
        output core_mode,
        output core_key,
        output core_key_valid,
        input  core_key_ready,
        output core_bdi,
        output core_bdi_valid,
        input  core_bdi_ready,
        output core_bdi_type,
        output core_bdi_eot,
        output core_bdi_eoi,
        input  core_bdo,
        input  core_bdo_valid,
        output core_bdo_ready,
        input  core_bdo_type,
        input  core_bdo_eot,
        output core_bdo_eoo,
        input  core_auth,
        input  core_auth_valid,
        input  core_done
    );

    modport master (
        output req_mode,
        input  req_start,
        input  req_grant,
        output req_key,
        output req_key_valid,
        input  req_key_ready,
        output req_bdi,
        output req_bdi_valid,
        input  req_bdi_ready,
        output req_bdi_type,
        output req_bdi_eot,
        output req_bdi_eoi,
        input  req_bdo,
        input  req_bdo_valid,
        output req_bdo_ready,
        input  req_bdo_type,
        input  req_bdo_eot,
        output req_bdo_eoo,
        input  req_done,
        input  req_auth,
        input  req_auth_valid,
        input  core_mode,
        input  core_key,
        input  core_key_valid,
        output core_key_ready,
        input  core_bdi,
        input  core_bdi_valid,
        output core_bdi_ready,
        input  core_bdi_type,
        input  core_bdi_eot,
        input  core_bdi_eoi,
        output core_bdo,
        output core_bdo_valid,
        input  core_bdo_ready,
        output core_bdo_type,
        output core_bdo_eot,
        input  core_bdo_eoo,
        output core_auth,
        output core_auth_valid,
        output core_done
    );
endinterface

// File: rtl/ascon_arbiter.sv
// Round-robin arbiter sharing one Ascon core between two requesters.
// The owner's streams are muxed straight through with zero latency.
module ascon_arbiter #(
    parameter int CCW = 32
) (
    input  logic           clk,
    input  logic           rst,
    ascon_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RETIRE} state_t;

    state_t         state;
    state_t         state_nx;
    logic           owner;
    logic           owner_nx;
    logic           last_owner;
    logic           last_nx;
    logic [1:0]     pending;
    logic           win;
    logic           fwd_in;
    logic           fwd_out;
    logic [CCW-1:0] key_w;
    logic [CCW-1:0] bdi_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last_owner;

        pending[0] = |bus.req_mode[0];
        pending[1] = |bus.req_mode[1];
        // on a tie the requester that did not go last wins
        win = (&pending) ? ~last_owner : pending[1];

        unique case (state)
            IDLE: begin
                if (|pending) begin
                    owner_nx = win;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = BUSY;
            BUSY: begin
                if (bus.core_done) begin
                    state_nx = RETIRE;
                end
            end
            RETIRE: begin
                last_nx  = owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // key/bdi already flow in ISSUE so the core sees them at mode accept
        fwd_in  = (state == ISSUE) || (state == BUSY);
        fwd_out = (state == BUSY);
        key_w   = bus.req_key[owner];
        bdi_w   = bus.req_bdi[owner];

        bus.core_mode = '0;
        if (state == ISSUE) begin
            bus.core_mode = bus.req_mode[owner];
        end

        bus.core_key       = fwd_in ? key_w : '0;
        bus.core_key_valid = fwd_in & bus.req_key_valid[owner];
        bus.core_bdi       = fwd_in ? bdi_w : '0;
        bus.core_bdi_valid = fwd_in ? bus.req_bdi_valid[owner] : '0;
        bus.core_bdi_type  = fwd_in ? bus.req_bdi_type[owner] : '0;
        bus.core_bdi_eot   = fwd_in & bus.req_bdi_eot[owner];
        bus.core_bdi_eoi   = fwd_in & bus.req_bdi_eoi[owner];
        bus.core_bdo_ready = fwd_out & bus.req_bdo_ready[owner];
        bus.core_bdo_eoo   = fwd_out & bus.req_bdo_eoo[owner];

        bus.req_start      = '0;
        bus.req_grant      = '0;
        bus.req_key_ready  = '0;
        bus.req_bdi_ready  = '0;
        bus.req_bdo        = '0;
        bus.req_bdo_valid  = '0;
        bus.req_bdo_type   = '0;
        bus.req_bdo_eot    = '0;
        bus.req_done       = '0;
        bus.req_auth       = '0;
        bus.req_auth_valid = '0;

        bus.req_start[owner]     = (state == ISSUE);
        bus.req_grant[owner]     = (state != IDLE);
        bus.req_key_ready[owner] = fwd_in & bus.core_key_ready;
        bus.req_bdi_ready[owner] = fwd_in & bus.core_bdi_ready;
        bus.req_done[owner]      = (state == RETIRE);

        if (fwd_out) begin
            bus.req_bdo[owner]       = bus.core_bdo;
            bus.req_bdo_valid[owner] = bus.core_bdo_valid;
            bus.req_bdo_type[owner]  = bus.core_bdo_type;
            bus.req_bdo_eot[owner]   = bus.core_bdo_eot;
        end

        if (state == RETIRE) begin
            bus.req_auth[owner]       = bus.core_auth;
            bus.req_auth_valid[owner] = bus.core_auth_valid;
        end
    end

endmodule
